// File: rtl/i2s_tx.sv
// I2S serialiser: buffers one stereo pair from a valid/ready source and shifts it out
// MSB-first with a one-slot delay after each WS edge, as directed by the frame_posn slot.
module i2s_tx #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               en,
    input  logic [5:0]         frame_posn,
    input  logic [WIDTH-1:0]   in_left,
    input  logic [WIDTH-1:0]   in_right,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               sd,
    output logic               underrun,
    output logic [COUNT_W-1:0] underrun_count
);

    localparam logic [4:0] W5 = 5'(WIDTH);

    logic [WIDTH-1:0]   hold_left;
    logic [WIDTH-1:0]   hold_right;
    logic               holding_full;
    logic               holding_full_next;
    logic [WIDTH-1:0]   shift_left;
    logic [WIDTH-1:0]   shift_right;
    logic               sd_p1;
    logic [COUNT_W-1:0] count_p1;

    logic               frame_start;
    logic               accept;
    logic [4:0]         slot;
    logic [4:0]         bit_idx;
    logic [WIDTH-1:0]   half_word;
    logic [WIDTH-1:0]   aligned;
    logic               bit_p0;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (&v)
            return v;
        return v + 1'b1;
    endfunction

    assign frame_start = en && (frame_posn == 6'd0);
    assign accept      = in_valid && !holding_full;
    assign in_ready    = !holding_full;
    assign underrun    = frame_start && !holding_full && !rst;

    // Accept and a full-holding load are mutually exclusive because accept needs empty.
    always_comb begin
        holding_full_next = holding_full;
        if (accept)
            holding_full_next = 1'b1;
        else if (frame_start && holding_full)
            holding_full_next = 1'b0;
    end

    // Stage p0: pick the bit for the current slot straight from frame_posn, no bit counter.
    always_comb begin
        slot      = frame_posn[4:0];
        half_word = frame_posn[5] ? shift_right : shift_left;
        bit_idx   = W5 - slot;
        aligned   = half_word >> bit_idx;
        bit_p0    = 1'b0;
        if ((slot >= 5'd1) && (slot <= W5))
            bit_p0 = aligned[0];
    end

    // Stage p1: registered serial output and shifter/holding state.
    always_ff @(posedge ck) begin
        if (rst) begin
            holding_full <= 1'b0;
            shift_left   <= '0;
            shift_right  <= '0;
            sd_p1        <= 1'b0;
            count_p1     <= '0;
        end else begin
            holding_full <= holding_full_next;
            if (frame_start) begin
                if (holding_full) begin
                    shift_left  <= hold_left;
                    shift_right <= hold_right;
                end else begin
                    shift_left  <= '0;
                    shift_right <= '0;
                    count_p1    <= sat_inc(count_p1);
                end
            end
            if (en)
                sd_p1 <= bit_p0;
        end
    end

    always_ff @(posedge ck) begin
        if (accept) begin
            hold_left  <= in_left;
            hold_right <= in_right;
        end
    end

    assign sd             = sd_p1;
    assign underrun_count = count_p1;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: en every 12 ck with frame_posn stepping 0..63, checking
// serial frames, handshake, underrun pulses and the saturating counter.
module tb_i2s_tx;

    localparam int W = 16;

    logic         ck = 1'b0;
    logic         rst;
    logic         en;
    logic [5:0]   frame_posn;
    logic [W-1:0] in_left;
    logic [W-1:0] in_right;
    logic         in_valid;
    logic         in_ready, sd, underrun;
    logic [7:0]   underrun_count;
    logic         in_ready2, sd2, underrun2;
    logic [1:0]   underrun_count2;

    always #5 ck = ~ck;

    i2s_tx #(.WIDTH(W), .COUNT_W(8)) dut (
        .ck(ck), .rst(rst), .en(en), .frame_posn(frame_posn),
        .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
        .in_ready(in_ready), .sd(sd), .underrun(underrun),
        .underrun_count(underrun_count)
    );

    i2s_tx #(.WIDTH(W), .COUNT_W(2)) dut2 (
        .ck(ck), .rst(rst), .en(en), .frame_posn(frame_posn),
        .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
        .in_ready(in_ready2), .sd(sd2), .underrun(underrun2),
        .underrun_count(underrun_count2)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] src_l [8];
    logic [W-1:0] src_r [8];
    int           src_n   = 0;
    int           src_idx = 0;
    bit           src_en  = 1'b0;
    bit           arm     = 1'b0;

    logic [63:0]  fr;
    int           fr_ur, fr_ur2, fr_acc, fr_unst;
    logic         rdy_start, rdy_end;

    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            f[1 + i]  = l[15 - i];
            f[33 + i] = r[15 - i];
        end
        return f;
    endfunction

    // One ck: drive at negedge, observe combinational outputs, then advance the source.
    task automatic cycle(input logic e, input logic [5:0] p);
        logic acc;
        @(negedge ck);
        en = e;
        frame_posn = p;
        if (arm && e && (p == 6'd0)) begin
            in_valid = 1'b1;
            arm = 1'b0;
        end
        #1;
        acc = in_valid & in_ready;
        if (underrun === 1'b1) fr_ur++;
        if (underrun2 === 1'b1) fr_ur2++;
        @(posedge ck);
        #1;
        if (acc) begin
            fr_acc++;
            if (src_en) begin
                src_idx++;
                if (src_idx < src_n) begin
                    in_left  = src_l[src_idx];
                    in_right = src_r[src_idx];
                end else begin
                    in_valid = 1'b0;
                    src_en   = 1'b0;
                end
            end
        end
    endtask

    task automatic slot(input logic [5:0] p);
        cycle(1'b1, p);
        fr[p] = sd;
        if (p == 6'd0) rdy_start = in_ready;
        repeat (11) begin
            cycle(1'b0, p);
            if (sd !== fr[p]) fr_unst++;
        end
    endtask

    task automatic clear_frame_stats;
        fr = '0; fr_ur = 0; fr_ur2 = 0; fr_acc = 0; fr_unst = 0;
    endtask

    task automatic run_frame;
        clear_frame_stats();
        for (int p = 0; p < 64; p++) slot(6'(p));
        rdy_end = in_ready;
    endtask

    task automatic do_reset;
        @(negedge ck);
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; src_en = 1'b0; arm = 1'b0;
        @(posedge ck);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; frame_posn = '0; in_valid = 1'b0;
        in_left = '0; in_right = '0;
        repeat (2) @(posedge ck);
        #1;
        checks++; if (sd !== 1'b0) begin errors++; $display("FAIL reset_sd got %0b want 0", sd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (underrun_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", underrun_count); end
        checks++; if (underrun_count2 !== 2'd0) begin errors++; $display("FAIL reset_count2 got %0d want 0", underrun_count2); end
        @(negedge ck);
        en = 1'b1; frame_posn = 6'd0;
        #1;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %0b want 0", underrun); end
        @(posedge ck);
        #1;
        checks++; if (underrun_count !== 8'd0) begin errors++; $display("FAIL reset_hold_count got %0d want 0", underrun_count); end
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_empty_frames;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            run_frame();
            checks++; if (fr !== 64'd0) begin errors++; $display("FAIL empty_sd frame %0d got %h want 0", k, fr); end
            checks++; if (fr_ur !== 1) begin errors++; $display("FAIL empty_pulses frame %0d got %0d want 1", k, fr_ur); end
            checks++; if (underrun_count !== 8'(k)) begin errors++; $display("FAIL empty_count got %0d want %0d", underrun_count, k); end
        end
    endtask

    task automatic test_single_pair;
        src_l[0] = 16'hA5C3; src_r[0] = 16'h0F01; src_n = 1; src_idx = 0; src_en = 1'b1;
        in_left = src_l[0]; in_right = src_r[0]; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pair_ready_before got %0b want 1", in_ready); end
        cycle(1'b0, 6'd0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pair_ready_after_accept got %0b want 0", in_ready); end
        run_frame();
        checks++; if (fr !== {15'b0, 16'h80F0, 16'h0000, 16'hC3A5, 1'b0}) begin
            errors++; $display("FAIL pair_frame got %h want %h", fr, {15'b0, 16'h80F0, 16'h0000, 16'hC3A5, 1'b0});
        end
        checks++; if (fr_ur !== 0) begin errors++; $display("FAIL pair_underrun got %0d want 0", fr_ur); end
        checks++; if (rdy_start !== 1'b1) begin errors++; $display("FAIL pair_ready_rise got %0b want 1", rdy_start); end
        checks++; if (fr_unst !== 0) begin errors++; $display("FAIL pair_sd_stable got %0d want 0", fr_unst); end
        checks++; if (underrun_count !== 8'd3) begin errors++; $display("FAIL pair_count got %0d want 3", underrun_count); end
    endtask

    task automatic test_back_to_back;
        src_l[0] = 16'h1234; src_r[0] = 16'h8001;
        src_l[1] = 16'hFFFF; src_r[1] = 16'h0000;
        src_l[2] = 16'h0001; src_r[2] = 16'hFFFE;
        src_l[3] = 16'h7E81; src_r[3] = 16'hC3C3;
        src_n = 4; src_idx = 0; src_en = 1'b1;
        in_left = src_l[0]; in_right = src_r[0]; in_valid = 1'b1;
        cycle(1'b0, 6'd0);
        for (int k = 0; k < 4; k++) begin
            run_frame();
            checks++; if (fr !== exp_frame(src_l[k], src_r[k])) begin
                errors++; $display("FAIL b2b_frame %0d got %h want %h", k, fr, exp_frame(src_l[k], src_r[k]));
            end
            checks++; if (fr_ur !== 0) begin errors++; $display("FAIL b2b_underrun %0d got %0d want 0", k, fr_ur); end
            checks++; if (fr_acc !== ((k < 3) ? 1 : 0)) begin
                errors++; $display("FAIL b2b_accepts %0d got %0d want %0d", k, fr_acc, (k < 3) ? 1 : 0);
            end
            checks++; if (rdy_end !== ((k < 3) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL b2b_ready_end %0d got %0b want %0b", k, rdy_end, (k < 3) ? 1'b0 : 1'b1);
            end
        end
        checks++; if (underrun_count !== 8'd3) begin errors++; $display("FAIL b2b_count got %0d want 3", underrun_count); end
    endtask

    task automatic test_same_cycle;
        src_l[0] = 16'h5A5A; src_r[0] = 16'h3C3C; src_n = 1; src_idx = 0; src_en = 1'b1;
        in_left = src_l[0]; in_right = src_r[0]; in_valid = 1'b0; arm = 1'b1;
        run_frame();
        checks++; if (fr_ur !== 1) begin errors++; $display("FAIL same_underrun got %0d want 1", fr_ur); end
        checks++; if (fr !== 64'd0) begin errors++; $display("FAIL same_zero_frame got %h want 0", fr); end
        checks++; if (fr_acc !== 1) begin errors++; $display("FAIL same_accept got %0d want 1", fr_acc); end
        run_frame();
        checks++; if (fr !== exp_frame(16'h5A5A, 16'h3C3C)) begin
            errors++; $display("FAIL same_next_frame got %h want %h", fr, exp_frame(16'h5A5A, 16'h3C3C));
        end
        checks++; if (fr_ur !== 0) begin errors++; $display("FAIL same_next_underrun got %0d want 0", fr_ur); end
        checks++; if (underrun_count !== 8'd4) begin errors++; $display("FAIL same_count got %0d want 4", underrun_count); end
    endtask

    task automatic test_reset_mid_frame;
        src_l[0] = 16'h8001; src_r[0] = 16'h0300;
        src_l[1] = 16'h1111; src_r[1] = 16'h2222;
        src_n = 2; src_idx = 0; src_en = 1'b1;
        in_left = src_l[0]; in_right = src_r[0]; in_valid = 1'b1;
        cycle(1'b0, 6'd0);
        clear_frame_stats();
        for (int p = 0; p < 40; p++) slot(6'(p));
        checks++; if (fr[39] !== 1'b1) begin errors++; $display("FAIL mid_sd_before got %0b want 1", fr[39]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_held got %0b want 0", in_ready); end
        rst = 1'b1;
        cycle(1'b1, 6'd40);
        rst = 1'b0;
        checks++; if (sd !== 1'b0) begin errors++; $display("FAIL mid_sd_after got %0b want 0", sd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b want 1", in_ready); end
        checks++; if (underrun_count !== 8'd0) begin errors++; $display("FAIL mid_count got %0d want 0", underrun_count); end
        for (int p = 41; p < 64; p++) slot(6'(p));
        checks++; if (fr[63:41] !== 23'd0) begin errors++; $display("FAIL mid_tail got %h want 0", fr[63:41]); end
        run_frame();
        checks++; if (fr_ur !== 1) begin errors++; $display("FAIL mid_next_underrun got %0d want 1", fr_ur); end
        checks++; if (fr !== 64'd0) begin errors++; $display("FAIL mid_next_frame got %h want 0", fr); end
        checks++; if (underrun_count !== 8'd1) begin errors++; $display("FAIL mid_next_count got %0d want 1", underrun_count); end
    endtask

    task automatic test_count_saturate;
        logic [1:0] want2;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            run_frame();
            want2 = (k < 3) ? 2'(k) : 2'd3;
            checks++; if (underrun_count2 !== want2) begin errors++; $display("FAIL sat_count2 frame %0d got %0d want %0d", k, underrun_count2, want2); end
            checks++; if (fr_ur2 !== 1) begin errors++; $display("FAIL sat_pulse2 frame %0d got %0d want 1", k, fr_ur2); end
            checks++; if (underrun_count !== 8'(k)) begin errors++; $display("FAIL sat_count8 frame %0d got %0d want %0d", k, underrun_count, k); end
        end
    endtask

    initial begin
        test_reset();
        test_empty_frames();
        test_single_pair();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid_frame();
        test_count_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
